// File: rtl/pc_source_reg.sv
// Next-PC selector and program-counter register: picks one of N_SRC sources or the
// exception vector, qualifies the update with write enables, and holds redirects across stalls.
module pc_source_reg #(
  parameter int          DATA_W     = 32,
  parameter int          N_SRC      = 6,
  parameter int          SEL_W      = $clog2(N_SRC),
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_00FC
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [N_SRC*DATA_W-1:0] src_flat,
  input  logic [SEL_W-1:0]        src_sel,
  input  logic                    pc_write,
  input  logic                    pc_write_cond,
  input  logic                    cond_zero,
  input  logic                    cond_invert,
  input  logic                    exc_req,
  input  logic                    stall,
  input  logic                    err_clr,
  output logic [DATA_W-1:0]       pc,
  output logic [DATA_W-1:0]       pc_prev,
  output logic                    pc_updated,
  output logic                    pending,
  output logic                    sel_err
);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] PENDING = 1'b1;
  localparam int unsigned NSRC_U = N_SRC;
  localparam logic [DATA_W-1:0] RESET_PC_W = DATA_W'(RESET_PC);
  localparam logic [DATA_W-1:0] EXC_VEC_W  = DATA_W'(EXC_VECTOR);

  logic [0:0]        state;
  logic [DATA_W-1:0] buffer;
  logic [DATA_W-1:0] src_pick;
  logic [DATA_W-1:0] target;
  logic              take;
  logic              sel_bad;
  logic              illegal;
  logic              legal_req;

  // Explicit compare-mux keeps out-of-range selects from indexing past src_flat.
  always_comb begin
    src_pick = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (src_sel == SEL_W'(i)) src_pick = src_flat[i*DATA_W +: DATA_W];
    end
  end

  assign take      = pc_write | (pc_write_cond & (cond_zero ^ cond_invert));
  assign sel_bad   = (32'(src_sel) >= NSRC_U);
  assign illegal   = take & ~exc_req & sel_bad;
  assign legal_req = exc_req | (take & ~sel_bad);
  assign target    = exc_req ? EXC_VEC_W : src_pick;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      buffer     <= '0;
      pc         <= RESET_PC_W;
      pc_prev    <= '0;
      pc_updated <= 1'b0;
      pending    <= 1'b0;
      sel_err    <= 1'b0;
    end else begin
      pc_updated <= 1'b0;
      // Set has priority over clear so a fresh error is never lost.
      if (illegal)      sel_err <= 1'b1;
      else if (err_clr) sel_err <= 1'b0;

      case (state)
        IDLE: begin
          if (legal_req) begin
            if (!stall) begin
              pc         <= target;
              pc_prev    <= pc;
              pc_updated <= 1'b1;
            end else begin
              buffer  <= target;
              pending <= 1'b1;
              state   <= PENDING;
            end
          end
        end
        PENDING: begin
          if (stall) begin
            // Only an exception may replace the buffered redirect.
            if (exc_req) buffer <= EXC_VEC_W;
          end else begin
            pc         <= exc_req ? EXC_VEC_W : buffer;
            pc_prev    <= pc;
            pc_updated <= 1'b1;
            pending    <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          pending <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_source_reg.sv
// Bench for pc_source_reg: directed test-plan sequences with literal expectations plus
// randomized traffic, all checked each cycle against a behavioural model.
module tb_pc_source_reg;
  localparam int N  = 6;
  localparam int DW = 32;
  localparam logic [31:0] EXC = 32'h0000_00FC;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [N*DW-1:0] src_flat;
  logic [2:0]    src_sel;
  logic          pc_write, pc_write_cond, cond_zero, cond_invert;
  logic          exc_req, stall, err_clr;
  logic [DW-1:0] pc, pc_prev;
  logic          pc_updated, pending, sel_err;

  logic [31:0] src [N];

  // Model state
  logic [31:0] m_pc, m_prev, m_buf;
  logic        m_upd, m_pend, m_err;

  int nvec = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  always_comb begin
    src_flat = '0;
    for (int i = 0; i < N; i++) src_flat[i*DW +: DW] = src[i];
  end

  pc_source_reg #(.DATA_W(DW), .N_SRC(N)) dut (
    .clk(clk), .reset_n(reset_n), .src_flat(src_flat), .src_sel(src_sel),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .cond_zero(cond_zero),
    .cond_invert(cond_invert), .exc_req(exc_req), .stall(stall), .err_clr(err_clr),
    .pc(pc), .pc_prev(pc_prev), .pc_updated(pc_updated), .pending(pending),
    .sel_err(sel_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference behaviour: what the PC register must do given this cycle's inputs.
  task automatic model_step();
    logic        taken, bad, want;
    logic [31:0] tgt;
    taken = pc_write || (pc_write_cond && (cond_zero != cond_invert));
    bad   = taken && !exc_req && (src_sel >= 3'(N));
    want  = exc_req || (taken && !bad);
    tgt   = exc_req ? EXC : (bad ? 32'h0 : src[src_sel]);
    if (!reset_n) begin
      m_pc = 32'h0; m_prev = 32'h0; m_buf = 32'h0;
      m_upd = 1'b0; m_pend = 1'b0; m_err = 1'b0;
    end else begin
      m_upd = 1'b0;
      if (bad) m_err = 1'b1;
      else if (err_clr) m_err = 1'b0;
      if (!m_pend) begin
        if (want && !stall) begin
          m_prev = m_pc; m_pc = tgt; m_upd = 1'b1;
        end else if (want) begin
          m_buf = tgt; m_pend = 1'b1;
        end
      end else if (stall) begin
        if (exc_req) m_buf = EXC;
      end else begin
        m_prev = m_pc; m_pc = exc_req ? EXC : m_buf; m_upd = 1'b1; m_pend = 1'b0;
      end
    end
  endtask

  // Advance one clock and compare every output against the model.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    chk("pc", pc, m_pc);
    chk("pc_prev", pc_prev, m_prev);
    chk("pc_updated", 32'(pc_updated), 32'(m_upd));
    chk("pending", 32'(pending), 32'(m_pend));
    chk("sel_err", 32'(sel_err), 32'(m_err));
  endtask

  task automatic idle_inputs();
    pc_write = 0; pc_write_cond = 0; cond_zero = 0; cond_invert = 0;
    exc_req = 0; stall = 0; err_clr = 0;
  endtask

  initial begin
    m_pc = 0; m_prev = 0; m_buf = 0; m_upd = 0; m_pend = 0; m_err = 0;
    for (int i = 0; i < N; i++) src[i] = 32'h100 * (i + 1);
    src[1] = 32'h0000_0044;
    src[2] = 32'h0040_0020;
    src[3] = 32'h0000_1000;
    src[4] = 32'h0000_2000;
    idle_inputs();
    src_sel = 3'd2;

    // Reset with pc_write held high
    reset_n = 0; pc_write = 1;
    cycle(); cycle();
    chk("rst_pc", pc, 32'h0);
    chk("rst_upd", 32'(pc_updated), 32'h0);
    chk("rst_pend", 32'(pending), 32'h0);
    chk("rst_err", 32'(sel_err), 32'h0);

    // Unconditional jump
    reset_n = 1; src_sel = 3'd2; pc_write = 1;
    cycle();
    chk("jmp_pc", pc, 32'h0040_0020);
    chk("jmp_prev", pc_prev, 32'h0);
    chk("jmp_upd", 32'(pc_updated), 32'h1);
    pc_write = 0;
    cycle();
    chk("jmp_upd_drop", 32'(pc_updated), 32'h0);

    // Conditional branch not taken, then taken via invert
    pc_write_cond = 1; cond_zero = 0; cond_invert = 0; src_sel = 3'd1;
    cycle();
    chk("br_nt_pc", pc, 32'h0040_0020);
    cond_invert = 1;
    cycle();
    chk("br_t_pc", pc, 32'h0000_0044);
    idle_inputs();

    // Stall buffering: first request wins
    stall = 1; pc_write = 1; src_sel = 3'd3;
    cycle();
    chk("stall_pend", 32'(pending), 32'h1);
    chk("stall_pc", pc, 32'h0000_0044);
    src_sel = 3'd4;
    cycle();
    pc_write = 0;
    cycle(); cycle();
    chk("stall_hold_pc", pc, 32'h0000_0044);
    stall = 0;
    cycle();
    chk("rel_pc", pc, 32'h0000_1000);
    chk("rel_pend", 32'(pending), 32'h0);
    chk("rel_upd", 32'(pc_updated), 32'h1);
    chk("rel_prev", pc_prev, 32'h0000_0044);

    // Exception overrides a buffered redirect
    stall = 1; pc_write = 1; src_sel = 3'd3;
    cycle();
    pc_write = 0; exc_req = 1;
    cycle();
    exc_req = 0; stall = 0;
    cycle();
    chk("exc_pc", pc, 32'h0000_00FC);
    chk("exc_prev", pc_prev, 32'h0000_1000);

    // Illegal select, sticky error, set beats clear
    pc_write = 1; src_sel = 3'd7;
    cycle();
    chk("ill_pc", pc, 32'h0000_00FC);
    chk("ill_err", 32'(sel_err), 32'h1);
    pc_write = 0;
    cycle();
    chk("ill_sticky", 32'(sel_err), 32'h1);
    pc_write = 1; err_clr = 1;
    cycle();
    chk("ill_setwins", 32'(sel_err), 32'h1);
    pc_write = 0;
    cycle();
    chk("ill_clr", 32'(sel_err), 32'h0);
    idle_inputs();

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      reset_n       = ($urandom_range(0, 199) != 0);
      stall         = ($urandom_range(0, 1) == 0);
      exc_req       = ($urandom_range(0, 9) == 0);
      pc_write      = ($urandom_range(0, 3) == 0);
      pc_write_cond = ($urandom_range(0, 3) == 0);
      cond_zero     = 1'($urandom_range(0, 1));
      cond_invert   = 1'($urandom_range(0, 1));
      err_clr       = ($urandom_range(0, 7) == 0);
      src_sel       = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) src[$urandom_range(0, N-1)] = $urandom;
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
